// File: rtl/ext_cpu_obi_pkg.sv
// OBI data-port request/response records and the redundancy mode encoding
// shared by the redundancy controller and its users.
package ext_cpu_obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    MODE_INDEP = 2'd0,
    MODE_DMR   = 2'd1,
    MODE_TMR   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

endpackage

// File: rtl/ext_cpu_redundancy_ctrl.sv
// Redundancy controller between the cve2 hart data ports and the system bus:
// independent pass-through, DMR compare or TMR vote, with drained mode switches.
module ext_cpu_redundancy_ctrl
  import ext_cpu_obi_pkg::*;
#(
  parameter int NHARTS  = 3,
  parameter int CNT_W   = 16,
  parameter int OUTST_W = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                mode_i,
  input  logic                      mode_req_i,
  output logic [1:0]                mode_o,
  output logic                      busy_o,
  input  obi_req_t  [NHARTS-1:0]    core_req_i,
  output obi_resp_t [NHARTS-1:0]    core_resp_o,
  output obi_req_t  [NHARTS-1:0]    bus_req_o,
  input  obi_resp_t [NHARTS-1:0]    bus_resp_i,
  input  logic                      clr_i,
  output logic [NHARTS-1:0]         mismatch_o,
  output logic                      fatal_o,
  output logic [NHARTS*CNT_W-1:0]   mismatch_cnt_o
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_e;

  // Third voter index; folds onto hart 1 when there is no hart 2 (TMR unreachable then).
  localparam int H2 = (NHARTS > 2) ? 2 : 1;

  state_e state_q, state_d;
  mode_e  mode_q, mode_d, target_q, target_d;

  logic [NHARTS-1:0][CNT_W-1:0]   cnt_q;
  logic [NHARTS-1:0][OUTST_W-1:0] outst_q;
  logic                           fatal_q;

  obi_req_t                       voted;
  obi_req_t [NHARTS-1:0]          bus_req;
  logic [NHARTS-1:0]              mm, grouped, inc;
  logic                           fatal_evt, eq01, eq02, eq12, mode_ok, busy;

  // Fields that do not matter for the access are masked before comparing.
  function automatic obi_req_t cmp_key(obi_req_t r);
    obi_req_t k;
    k = r;
    if (!r.we) begin
      k.be    = '0;
      k.wdata = '0;
    end
    if (!r.req) k = '0;
    return k;
  endfunction

  assign eq01 = cmp_key(core_req_i[0]) == cmp_key(core_req_i[1]);
  assign eq02 = cmp_key(core_req_i[0]) == cmp_key(core_req_i[H2]);
  assign eq12 = cmp_key(core_req_i[1]) == cmp_key(core_req_i[H2]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    voted     = core_req_i[0];
    mm        = '0;
    fatal_evt = 1'b0;
    case (mode_q)
      MODE_DMR: begin
        if (!eq01) begin
          mm[0]     = 1'b1;
          mm[1]     = 1'b1;
          fatal_evt = 1'b1;
        end
      end
      MODE_TMR: begin
        if (NHARTS > 2 && !(eq01 && eq02)) begin
          if (eq01)       mm[H2] = 1'b1;
          else if (eq02)  mm[1]  = 1'b1;
          else if (eq12) begin
            voted = core_req_i[1];
            mm[0] = 1'b1;
          end else begin
            mm[0]     = 1'b1;
            mm[1]     = 1'b1;
            mm[H2]    = 1'b1;
            fatal_evt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_RUN);

  // Routing follows mode_q, which only changes in SWITCH, so in-flight responses
  // reach the harts of the old grouping. Handshakes stay blocked through SWITCH too.
  always_comb begin
    for (int i = 0; i < NHARTS; i++) begin
      grouped[i]     = (mode_q == MODE_DMR && i < 2) || (mode_q == MODE_TMR && i < 3);
      bus_req[i]     = core_req_i[i];
      core_resp_o[i] = bus_resp_i[i];
      if (grouped[i]) begin
        bus_req[i]     = (i == 0) ? voted : '0;
        core_resp_o[i] = bus_resp_i[0];
      end
      if (busy) begin
        bus_req[i].req     = 1'b0;
        core_resp_o[i].gnt = 1'b0;
      end
      inc[i] = bus_req[i].req & bus_resp_i[i].gnt;
    end
  end

  assign bus_req_o = bus_req;

  assign mode_ok = (mode_i != MODE_RSVD) && (mode_i != mode_q) &&
                   !(mode_i == MODE_TMR && NHARTS < 3);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    case (state_q)
      ST_RUN: begin
        if (mode_req_i && mode_ok) begin
          target_d = mode_e'(mode_i);
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN:  if (outst_q == '0) state_d = ST_SWITCH;
      ST_SWITCH: begin
        mode_d  = target_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      mode_q   <= MODE_INDEP;
      target_q <= MODE_INDEP;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
    end
  end

  // NOTE: the counter arrays are flops, not RAM, so they take the async reset like any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      fatal_q <= 1'b0;
      outst_q <= '0;
    end else begin
      for (int i = 0; i < NHARTS; i++) begin
        if (clr_i)                         cnt_q[i] <= '0;
        else if (mm[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);

        if (inc[i] && !bus_resp_i[i].rvalid && outst_q[i] != '1)
          outst_q[i] <= outst_q[i] + OUTST_W'(1);
        else if (!inc[i] && bus_resp_i[i].rvalid && outst_q[i] != '0)
          outst_q[i] <= outst_q[i] - OUTST_W'(1);
      end
      if (clr_i)          fatal_q <= 1'b0;
      else if (fatal_evt) fatal_q <= 1'b1;
    end
  end

  assign mode_o         = mode_q;
  assign busy_o         = busy;
  assign mismatch_o     = mm;
  assign fatal_o        = fatal_q;
  assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_ext_cpu_redundancy_ctrl.sv
// Self-checking bench for ext_cpu_redundancy_ctrl: vector table for voting,
// response scoreboard, hand-written drain/switch and reset sequences.
module tb_ext_cpu_redundancy_ctrl;
  import ext_cpu_obi_pkg::*;

  localparam int NH = 3;
  localparam int CW = 2;
  localparam int OW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [1:0]            mode_i, mode_o;
  logic                  mode_req_i, busy_o, clr_i, fatal_o;
  obi_req_t  [NH-1:0]    core_req, bus_req;
  obi_resp_t [NH-1:0]    core_resp, bus_resp;
  logic [NH-1:0]         mismatch_o;
  logic [NH*CW-1:0]      mismatch_cnt_o;

  ext_cpu_redundancy_ctrl #(.NHARTS(NH), .CNT_W(CW), .OUTST_W(OW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .mode_i         (mode_i),
    .mode_req_i     (mode_req_i),
    .mode_o         (mode_o),
    .busy_o         (busy_o),
    .core_req_i     (core_req),
    .core_resp_o    (core_resp),
    .bus_req_o      (bus_req),
    .bus_resp_i     (bus_resp),
    .clr_i          (clr_i),
    .mismatch_o     (mismatch_o),
    .fatal_o        (fatal_o),
    .mismatch_cnt_o (mismatch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  mode;
    logic        clr;
    obi_req_t    r0, r1, r2;
    logic        exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [2:0]  exp_mm;
    logic        fat;
  } vec_t;

  typedef struct {
    int          hart;
    logic [31:0] rdata;
  } rsp_t;

  vec_t vecs[14];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt[NH];
  logic m_fatal;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obi_req_t rq(input logic [31:0] addr, input logic we,
                                  input logic [3:0] be, input logic [31:0] wdata);
    return {1'b1, addr, we, be, wdata};
  endfunction

  function automatic obi_req_t nr(input logic [31:0] addr);
    return {1'b0, addr, 1'b1, 4'hF, addr};
  endfunction

  task automatic idle();
    core_req   = '0;
    bus_resp   = '0;
    clr_i      = 1'b0;
    mode_req_i = 1'b0;
  endtask

  // Compares every rvalid delivered to a hart against the queued expectations.
  task automatic sb_sample();
    rsp_t e;
    for (int h = 0; h < NH; h++) begin
      if (core_resp[h].rvalid) begin
        if (rsp_q.size() == 0) begin
          check($sformatf("rsp_unexpected_h%0d", h), core_resp[h].rvalid, 1'b0);
        end else begin
          e = rsp_q.pop_front();
          check($sformatf("rsp_hart_h%0d", h), h, e.hart);
          check($sformatf("rsp_rdata_h%0d", h), core_resp[h].rdata, e.rdata);
        end
      end
    end
    check("rsp_missing", rsp_q.size(), 0);
    rsp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < NH; i++)
      check($sformatf("%s_cnt%0d", tag, i), mismatch_cnt_o[i*CW +: CW], m_cnt[i]);
    check({tag, "_fatal"}, fatal_o, m_fatal);
  endtask

  task automatic switch_mode(input logic [1:0] m);
    @(negedge clk_i);
    idle();
    mode_i     = m;
    mode_req_i = 1'b1;
    @(negedge clk_i);
    mode_req_i = 1'b0;
    for (int c = 0; c < 20 && !(mode_o == m && !busy_o); c++) @(negedge clk_i);
    check("switch_mode", mode_o, m);
    check("switch_busy", busy_o, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    obi_req_t exp2;
    @(negedge clk_i);
    core_req[0] = v.r0;
    core_req[1] = v.r1;
    core_req[2] = v.r2;
    clr_i       = v.clr;
    mode_req_i  = 1'b0;
    bus_resp[0] = {1'b0, 1'b1, 32'hA000_0000 | 32'(idx)};
    bus_resp[1] = {1'b0, 1'b1, 32'hB000_0000 | 32'(idx)};
    bus_resp[2] = {1'b0, 1'b1, 32'hC000_0000 | 32'(idx)};
    rsp_q.push_back('{0, 32'hA000_0000 | 32'(idx)});
    rsp_q.push_back('{1, 32'hA000_0000 | 32'(idx)});
    rsp_q.push_back('{2, (v.mode == 2'd2) ? (32'hA000_0000 | 32'(idx)) : (32'hC000_0000 | 32'(idx))});
    #1;
    check($sformatf("v%0d_req0", idx), bus_req[0].req, v.exp_req);
    if (v.exp_req) begin
      check($sformatf("v%0d_addr0", idx), bus_req[0].addr, v.exp_addr);
      check($sformatf("v%0d_we0", idx), bus_req[0].we, v.exp_we);
      if (v.exp_we) check($sformatf("v%0d_wdata0", idx), bus_req[0].wdata, v.exp_wdata);
    end
    check($sformatf("v%0d_bus1", idx), bus_req[1], '0);
    exp2 = (v.mode == 2'd2) ? '0 : v.r2;
    check($sformatf("v%0d_bus2", idx), bus_req[2], exp2);
    check($sformatf("v%0d_mismatch", idx), mismatch_o, v.exp_mm);
    sb_sample();
    for (int i = 0; i < NH; i++) begin
      if (v.clr)                                  m_cnt[i] = 0;
      else if (v.exp_mm[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
    end
    if (v.clr)      m_fatal = 1'b0;
    else if (v.fat) m_fatal = 1'b1;
    @(posedge clk_i);
    #1;
    check_counters($sformatf("v%0d", idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    // {mode, clr, r0, r1, r2, exp_req, exp_we, exp_addr, exp_wdata, exp_mm, fatal}
    vecs[0]  = '{2'd2, 1'b0, rq(32'h40, 1, 4'hF, 32'hDEADBEEF), rq(32'h40, 1, 4'hF, 32'hDEADBEEF),
                 rq(32'h40, 1, 4'hF, 32'hDEADBEEF), 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 3'b000, 1'b0};
    vecs[1]  = '{2'd2, 1'b0, rq(32'h40, 1, 4'hF, 32'hDEADBEEF), rq(32'h40, 1, 4'hF, 32'hDEADBEEE),
                 rq(32'h40, 1, 4'hF, 32'hDEADBEEF), 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 3'b010, 1'b0};
    vecs[2]  = '{2'd2, 1'b0, rq(32'h44, 1, 4'hF, 32'h1234), rq(32'h40, 1, 4'hF, 32'h1234),
                 rq(32'h40, 1, 4'hF, 32'h1234), 1'b1, 1'b1, 32'h40, 32'h1234, 3'b001, 1'b0};
    vecs[3]  = '{2'd2, 1'b0, nr(32'h1), nr(32'h2), nr(32'h3), 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0};
    vecs[4]  = '{2'd2, 1'b0, rq(32'h80, 0, 4'hF, 32'h1), rq(32'h80, 0, 4'h3, 32'h2),
                 rq(32'h80, 0, 4'h1, 32'h3), 1'b1, 1'b0, 32'h80, 32'h0, 3'b000, 1'b0};
    vecs[5]  = '{2'd2, 1'b0, rq(32'h48, 1, 4'hF, 32'h5), rq(32'h48, 1, 4'hF, 32'h5),
                 rq(32'h48, 0, 4'hF, 32'h5), 1'b1, 1'b1, 32'h48, 32'h5, 3'b100, 1'b0};
    vecs[6]  = '{2'd2, 1'b0, rq(32'h10, 0, 4'hF, 32'h0), rq(32'h14, 0, 4'hF, 32'h0),
                 rq(32'h18, 0, 4'hF, 32'h0), 1'b1, 1'b0, 32'h10, 32'h0, 3'b111, 1'b1};
    vecs[7]  = '{2'd2, 1'b0, rq(32'h20, 0, 4'hF, 32'h0), rq(32'h20, 0, 4'hF, 32'h0),
                 rq(32'h20, 0, 4'hF, 32'h0), 1'b1, 1'b0, 32'h20, 32'h0, 3'b000, 1'b0};
    vecs[8]  = '{2'd2, 1'b1, '0, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0};
    vecs[9]  = '{2'd1, 1'b0, rq(32'h60, 1, 4'hF, 32'h1), rq(32'h60, 1, 4'hF, 32'h2),
                 rq(32'h500, 0, 4'hF, 32'h0), 1'b1, 1'b1, 32'h60, 32'h1, 3'b011, 1'b1};
    vecs[10] = '{2'd1, 1'b0, rq(32'h60, 1, 4'hF, 32'h3), rq(32'h60, 1, 4'hF, 32'h4),
                 rq(32'h500, 0, 4'hF, 32'h0), 1'b1, 1'b1, 32'h60, 32'h3, 3'b011, 1'b1};
    vecs[11] = '{2'd1, 1'b0, rq(32'h64, 1, 4'hF, 32'h5), rq(32'h64, 1, 4'hF, 32'h6),
                 rq(32'h500, 0, 4'hF, 32'h0), 1'b1, 1'b1, 32'h64, 32'h5, 3'b011, 1'b1};
    vecs[12] = '{2'd1, 1'b0, rq(32'h68, 1, 4'hF, 32'h7), rq(32'h68, 1, 4'hF, 32'h8),
                 rq(32'h500, 0, 4'hF, 32'h0), 1'b1, 1'b1, 32'h68, 32'h7, 3'b011, 1'b1};
    vecs[13] = '{2'd1, 1'b0, rq(32'h70, 0, 4'hF, 32'h9), rq(32'h70, 0, 4'h1, 32'hA),
                 rq(32'h504, 0, 4'hF, 32'h0), 1'b1, 1'b0, 32'h70, 32'h0, 3'b000, 1'b0};

    for (int i = 0; i < NH; i++) m_cnt[i] = 0;
    m_fatal = 1'b0;
    rst_ni  = 1'b0;
    mode_i  = 2'd0;
    idle();
    repeat (3) @(negedge clk_i);
    check("rst_mode", mode_o, 2'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_mismatch", mismatch_o, 3'b000);
    check_counters("rst");
    rst_ni = 1'b1;

    // INDEP: three distinct reads pass straight through, responses per port.
    @(negedge clk_i);
    for (int i = 0; i < NH; i++) begin
      core_req[i]     = rq(32'h100 * (i + 1), 1'b0, 4'hF, 32'h0);
      bus_resp[i].gnt = 1'b1;
    end
    #1;
    for (int i = 0; i < NH; i++) begin
      check($sformatf("indep_req%0d", i), bus_req[i].req, 1'b1);
      check($sformatf("indep_addr%0d", i), bus_req[i].addr, 32'h100 * (i + 1));
      check($sformatf("indep_gnt%0d", i), core_resp[i].gnt, 1'b1);
    end
    check("indep_mismatch", mismatch_o, 3'b000);
    @(negedge clk_i);
    idle();
    for (int i = 0; i < NH; i++) begin
      bus_resp[i] = {1'b0, 1'b1, 32'h0000_1000 + 32'(i)};
      rsp_q.push_back('{i, 32'h0000_1000 + 32'(i)});
    end
    #1;
    sb_sample();

    // Switch to TMR with one read outstanding on hart 1.
    @(negedge clk_i);
    idle();
    core_req[1]     = rq(32'h204, 1'b0, 4'hF, 32'h0);
    bus_resp[1].gnt = 1'b1;
    #1;
    check("drain_pre_gnt1", core_resp[1].gnt, 1'b1);
    @(negedge clk_i);
    idle();
    mode_i     = 2'd2;
    mode_req_i = 1'b1;
    @(negedge clk_i);
    mode_req_i      = 1'b0;
    core_req[0]     = rq(32'h300, 1'b0, 4'hF, 32'h0);
    bus_resp[0].gnt = 1'b1;
    #1;
    check("drain_busy", busy_o, 1'b1);
    check("drain_gnt_blocked", core_resp[0].gnt, 1'b0);
    check("drain_req_blocked", bus_req[0].req, 1'b0);
    repeat (3) @(negedge clk_i);
    check("drain_still_busy", busy_o, 1'b1);
    check("drain_still_mode", mode_o, 2'd0);
    idle();
    bus_resp[1] = {1'b0, 1'b1, 32'h0000_55AA};
    rsp_q.push_back('{1, 32'h0000_55AA});
    #1;
    sb_sample();
    @(negedge clk_i);
    idle();
    check("drain_after_rvalid_mode", mode_o, 2'd0);
    check("drain_after_rvalid_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("switch_cycle_mode", mode_o, 2'd0);
    check("switch_cycle_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("tmr_active_mode", mode_o, 2'd2);
    check("tmr_active_busy", busy_o, 1'b0);

    for (int k = 0; k < 14; k++) begin
      if (vecs[k].mode != mode_o) switch_mode(vecs[k].mode);
      apply_vec(vecs[k], k);
    end

    // Reset while draining a DMR->INDEP switch with a read in flight on port 2.
    @(negedge clk_i);
    idle();
    core_req[2]     = rq(32'h600, 1'b0, 4'hF, 32'h0);
    bus_resp[2].gnt = 1'b1;
    @(negedge clk_i);
    idle();
    mode_i     = 2'd0;
    mode_req_i = 1'b1;
    @(negedge clk_i);
    mode_req_i = 1'b0;
    #1;
    check("rst_drain_busy_before", busy_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < NH; i++) m_cnt[i] = 0;
    m_fatal = 1'b0;
    check("rst_drain_mode", mode_o, 2'd0);
    check("rst_drain_busy", busy_o, 1'b0);
    check_counters("rst_drain");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    mode_i     = 2'd3;
    mode_req_i = 1'b1;
    @(negedge clk_i);
    mode_req_i = 1'b0;
    #1;
    check("rsvd_busy", busy_o, 1'b0);
    check("rsvd_mode", mode_o, 2'd0);
    @(negedge clk_i);
    check("rsvd_busy_later", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
